// File: rtl/ahb_data_mem_if.sv
// AHB-Lite bus bundle between the Cortex-M0 data-bus interconnect and the data memory.
// The master side also carries the interconnect's HREADY.
interface ahb_data_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_data_mem.sv
// AHB-Lite slave data memory: pipelined address/data phases, optional wait states,
// alignment/range ERROR response and selectable byte ordering.
module ahb_data_mem #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    ahb_data_mem_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WaitLoad = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;

    logic [7:0] mem [DEPTH_BYTES];

    logic          ready_state;
    logic          accept;
    logic          req_err;
    logic          mem_we;
    int            nbytes;
    int            lane;
    logic [3:0]    byte_en;
    logic [7:0]    wr_byte [4];
    logic [AW-1:0] byte_idx [4];
    logic [31:0]   rd_word;
    logic          unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    // A new address phase can only be taken while this slave is not stalling the bus.
    assign ready_state = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept      = ready_state && bus.HSEL && bus.HTRANS[1] && bus.HREADY;

    assign req_err = (bus.HSIZE > 3'b010)
                  || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                  || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00))
                  || (bus.HADDR >= 32'(DEPTH_BYTES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                state_d = StIdle;
                if (accept) begin
                    addr_d  = bus.HADDR[AW-1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE[1:0];
                    if (req_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Byte i of the transfer lives at addr+i; its bus lane depends on the byte ordering.
    always_comb begin
        nbytes  = 4;
        lane    = 0;
        byte_en = '0;
        wr_byte = '{default: '0};
        rd_word = '0;
        case (size_q)
            2'b00:   nbytes = 1;
            2'b01:   nbytes = 2;
            default: nbytes = 4;
        endcase
        for (int i = 0; i < 4; i++) begin
            byte_idx[i] = addr_q + AW'(i);
            if (i < nbytes) begin
                lane                 = BIG_ENDIAN ? (nbytes - 1 - i) : i;
                byte_en[i]           = 1'b1;
                wr_byte[i]           = bus.HWDATA[8*lane +: 8];
                rd_word[8*lane +: 8] = mem[byte_idx[i]];
            end
        end
    end

    assign mem_we = rst_n && (state_q == StData) && write_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[byte_idx[i]] <= wr_byte[i];
                end
            end
        end
    end

    assign bus.HRDATA    = ((state_q == StData) && !write_q) ? rd_word : 32'h0;
    assign bus.HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
    assign bus.HRESP     = (state_q == StErr1) || (state_q == StErr2);

endmodule

// File: tb/tb_ahb_data_mem.sv
// Directed bench for ahb_data_mem: three instances cover big/little endian and wait states.
module tb_ahb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        block_rdy;
    logic        hready;
    int          cur_dut;
    logic        s_rdy, s_resp;
    logic [31:0] s_rdata;
    int          checks = 0;
    int          errors = 0;

    // Transfer table consumed by run_seq
    logic        t_wr    [8];
    logic [2:0]  t_size  [8];
    logic [31:0] t_addr  [8];
    logic [31:0] t_wdata [8];
    logic [31:0] r_rdata [8];
    logic        r_resp  [8];
    logic        r_resp0 [8];
    int          r_waits [8];
    int          t_n;

    always #5 clk = ~clk;

    ahb_data_mem_if bus0 ();
    ahb_data_mem_if bus1 ();
    ahb_data_mem_if bus2 ();

    assign bus0.HSEL = hsel[0]; assign bus0.HADDR = haddr; assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite; assign bus0.HSIZE = hsize; assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = hready;
    assign bus1.HSEL = hsel[1]; assign bus1.HADDR = haddr; assign bus1.HTRANS = htrans;
    assign bus1.HWRITE = hwrite; assign bus1.HSIZE = hsize; assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = hready;
    assign bus2.HSEL = hsel[2]; assign bus2.HADDR = haddr; assign bus2.HTRANS = htrans;
    assign bus2.HWRITE = hwrite; assign bus2.HSIZE = hsize; assign bus2.HWDATA = hwdata;
    assign bus2.HREADY = hready;

    assign hready = bus0.HREADYOUT & bus1.HREADYOUT & bus2.HREADYOUT & !block_rdy;

    ahb_data_mem #(.DEPTH_BYTES(4096), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) u_dut_be (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    ahb_data_mem #(.DEPTH_BYTES(4096), .WAIT_STATES(0), .BIG_ENDIAN(1'b0)) u_dut_le (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    ahb_data_mem #(.DEPTH_BYTES(4096), .WAIT_STATES(3), .BIG_ENDIAN(1'b1)) u_dut_ws (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    always_comb begin
        s_rdy   = bus0.HREADYOUT;
        s_resp  = bus0.HRESP;
        s_rdata = bus0.HRDATA;
        if (cur_dut == 1) begin
            s_rdy = bus1.HREADYOUT; s_resp = bus1.HRESP; s_rdata = bus1.HRDATA;
        end else if (cur_dut == 2) begin
            s_rdy = bus2.HREADYOUT; s_resp = bus2.HRESP; s_rdata = bus2.HRDATA;
        end
    end

    task automatic add(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
        t_wr[t_n] = wr; t_size[t_n] = sz; t_addr[t_n] = a; t_wdata[t_n] = d;
        t_n++;
    endtask

    // Pipelined AHB master: called and returns at a negedge with the bus idle.
    task automatic run_seq();
        int dp, ap, nxt, cyc;
        bit rdy, first;
        dp = -1; ap = 0; cyc = 0; first = 1'b0;
        for (int i = 0; i < t_n; i++) begin
            r_waits[i] = 0; r_resp[i] = 1'b0; r_resp0[i] = 1'b0; r_rdata[i] = '0;
        end
        while ((ap < t_n || dp >= 0) && cyc < 100) begin
            rdy = hready;
            nxt = dp;
            if (dp >= 0) begin
                if (first) begin
                    r_resp0[dp] = s_resp;
                    first = 1'b0;
                end
                if (!rdy) begin
                    r_waits[dp]++;
                end else begin
                    r_rdata[dp] = s_rdata;
                    r_resp[dp]  = s_resp;
                    nxt = -1;
                end
            end
            if (rdy) begin
                if (ap < t_n) begin
                    hsel = 3'b001 << cur_dut; htrans = 2'b10; haddr = t_addr[ap];
                    hwrite = t_wr[ap]; hsize = t_size[ap];
                    nxt = ap;
                    ap++;
                end else begin
                    hsel = 3'b000; htrans = 2'b00;
                end
            end
            @(posedge clk);
            if (nxt != dp) begin
                dp = nxt;
                first = (dp >= 0);
            end
            @(negedge clk);
            if (dp >= 0 && first) hwdata = t_wdata[dp];
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL run_seq_timeout: issued %0d of %0d, required completion", ap, t_n);
            hsel = 3'b000; htrans = 2'b00;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_be: got rdy=%b resp=%b rdata=%h required 1 0 0",
                     bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA);
        end
        checks++;
        if ({bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_le: got rdy=%b resp=%b rdata=%h required 1 0 0",
                     bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA);
        end
        checks++;
        if ({bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_ws: got rdy=%b resp=%b rdata=%h required 1 0 0",
                     bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_big_endian();
        cur_dut = 0; t_n = 0;
        add(1'b1, 3'b010, 32'h10, 32'h11223344);
        add(1'b0, 3'b010, 32'h10, 32'h0);
        add(1'b0, 3'b000, 32'h10, 32'h0);
        add(1'b0, 3'b001, 32'h12, 32'h0);
        run_seq();
        checks++;
        if (r_rdata[1] !== 32'h11223344) begin
            errors++; $display("FAIL be_word_read: got %h required %h", r_rdata[1], 32'h11223344);
        end
        checks++;
        if (r_rdata[2] !== 32'h00000011) begin
            errors++; $display("FAIL be_byte_read: got %h required %h", r_rdata[2], 32'h11);
        end
        checks++;
        if (r_rdata[3] !== 32'h00003344) begin
            errors++; $display("FAIL be_half_read: got %h required %h", r_rdata[3], 32'h3344);
        end
        checks++;
        if ((r_waits[0] + r_waits[1] + r_waits[2] + r_waits[3]) != 0 || r_resp[1] !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_wait: got waits=%0d resp=%b required 0 0",
                     r_waits[0] + r_waits[1] + r_waits[2] + r_waits[3], r_resp[1]);
        end
    endtask

    task automatic test_little_endian();
        cur_dut = 1; t_n = 0;
        add(1'b1, 3'b010, 32'h10, 32'h11223344);
        add(1'b0, 3'b000, 32'h10, 32'h0);
        add(1'b0, 3'b001, 32'h12, 32'h0);
        add(1'b1, 3'b000, 32'h11, 32'hFFFFFFAB);
        add(1'b0, 3'b010, 32'h10, 32'h0);
        run_seq();
        checks++;
        if (r_rdata[1] !== 32'h00000044) begin
            errors++; $display("FAIL le_byte_read: got %h required %h", r_rdata[1], 32'h44);
        end
        checks++;
        if (r_rdata[2] !== 32'h00001122) begin
            errors++; $display("FAIL le_half_read: got %h required %h", r_rdata[2], 32'h1122);
        end
        checks++;
        if (r_rdata[4] !== 32'h1122AB44) begin
            errors++; $display("FAIL le_byte_write: got %h required %h", r_rdata[4], 32'h1122AB44);
        end
    endtask

    task automatic test_wait_states();
        cur_dut = 2; t_n = 0;
        add(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        add(1'b0, 3'b010, 32'h40, 32'h0);
        run_seq();
        checks++;
        if (r_waits[0] != 3 || r_waits[1] != 3) begin
            errors++;
            $display("FAIL ws_back_to_back_waits: got %0d/%0d required 3/3", r_waits[0], r_waits[1]);
        end
        checks++;
        if (r_rdata[1] !== 32'hCAFEF00D || r_resp[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws_raw_read: got %h resp=%b required cafef00d 0", r_rdata[1], r_resp[1]);
        end
        t_n = 0;
        add(1'b0, 3'b001, 32'h42, 32'h0);
        run_seq();
        checks++;
        if (r_waits[0] != 3 || r_rdata[0] !== 32'h0000F00D) begin
            errors++;
            $display("FAIL ws_single_read: got waits=%0d data=%h required 3 0000f00d",
                     r_waits[0], r_rdata[0]);
        end
    endtask

    task automatic test_errors();
        cur_dut = 0; t_n = 0;
        add(1'b1, 3'b010, 32'h0, 32'hA5A5A5A5);
        add(1'b1, 3'b010, 32'h4, 32'h5A5A5A5A);
        add(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF);
        add(1'b0, 3'b001, 32'h1, 32'h0);
        add(1'b1, 3'b011, 32'h4, 32'hFFFFFFFF);
        add(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF);
        add(1'b0, 3'b010, 32'h0, 32'h0);
        add(1'b0, 3'b010, 32'h4, 32'h0);
        run_seq();
        for (int i = 2; i < 6; i++) begin
            checks++;
            if (r_resp0[i] !== 1'b1 || r_resp[i] !== 1'b1 || r_waits[i] != 1 ||
                r_rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL err_resp_%0d: got resp=%b/%b waits=%0d data=%h required 1/1 1 0",
                         i, r_resp0[i], r_resp[i], r_waits[i], r_rdata[i]);
            end
        end
        checks++;
        if (r_rdata[6] !== 32'hA5A5A5A5 || r_resp[6] !== 1'b0 || r_waits[6] != 0) begin
            errors++;
            $display("FAIL err_mem_0: got %h resp=%b waits=%0d required a5a5a5a5 0 0",
                     r_rdata[6], r_resp[6], r_waits[6]);
        end
        checks++;
        if (r_rdata[7] !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL err_mem_4: got %h required %h", r_rdata[7], 32'h5A5A5A5A);
        end
    endtask

    task automatic test_pipeline();
        logic [31:0] exp [4];
        exp[0] = 32'hA5A5A5A5; exp[1] = 32'h5A5A5A5A; exp[2] = 32'h01020304; exp[3] = 32'h0A0B0C0D;
        cur_dut = 0; t_n = 0;
        add(1'b1, 3'b010, 32'h8, 32'h01020304);
        add(1'b1, 3'b010, 32'hC, 32'h0A0B0C0D);
        run_seq();
        t_n = 0;
        for (int i = 0; i < 4; i++) add(1'b0, 3'b010, 32'(4 * i), 32'h0);
        run_seq();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_rdata[i] !== exp[i] || r_waits[i] != 0) begin
                errors++;
                $display("FAIL pipe_read_%0d: got %h waits=%0d required %h 0",
                         i, r_rdata[i], r_waits[i], exp[i]);
            end
        end
    endtask

    task automatic test_hready_low();
        cur_dut = 0;
        block_rdy = 1'b1;
        hsel = 3'b001; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk);
        @(negedge clk);
        hsel = 3'b000; htrans = 2'b00;
        checks++;
        if (s_rdy !== 1'b1 || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL hready_low_no_accept: got rdy=%b data=%h required 1 0", s_rdy, s_rdata);
        end
        block_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cur_dut = 2; t_n = 0;
        add(1'b1, 3'b010, 32'h20, 32'h12345678);
        run_seq();
        hsel = 3'b100; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk);
        @(negedge clk);
        hsel = 3'b000; htrans = 2'b00; hwdata = 32'hDEADBEEF;
        checks++;
        if (s_rdy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_in_wait: got rdy=%b required 0", s_rdy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({s_rdy, s_resp, s_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_outputs: got rdy=%b resp=%b data=%h required 1 0 0",
                     s_rdy, s_resp, s_rdata);
        end
        t_n = 0;
        add(1'b0, 3'b010, 32'h20, 32'h0);
        run_seq();
        checks++;
        if (r_rdata[0] !== 32'h12345678) begin
            errors++; $display("FAIL rst_mid_wait_nowrite: got %h required 12345678", r_rdata[0]);
        end
        // Reset landing on the completing edge of a zero-wait write
        cur_dut = 0; t_n = 0;
        add(1'b1, 3'b010, 32'h30, 32'h12345678);
        run_seq();
        hsel = 3'b001; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk);
        @(negedge clk);
        hsel = 3'b000; htrans = 2'b00; hwdata = 32'hDEADBEEF;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t_n = 0;
        add(1'b0, 3'b010, 32'h30, 32'h0);
        run_seq();
        checks++;
        if (r_rdata[0] !== 32'h12345678) begin
            errors++; $display("FAIL rst_mid_data_nowrite: got %h required 12345678", r_rdata[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; hsel = 3'b000; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b000; hwdata = '0; block_rdy = 1'b0; cur_dut = 0; t_n = 0;
        @(negedge clk);
        test_reset();
        test_big_endian();
        test_little_endian();
        test_wait_states();
        test_errors();
        test_pipeline();
        test_hready_low();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
